huffman_block_sequencer: RTL and testbench

Parametrised successor to the fixed 64-coefficient Huffman controller. It accepts one zigzag-ordered quantised block per handshake and keeps a DC predictor per colour component. It scans the AC coefficients one per cycle and emits a backpressured stream of JPEG symbols (DC, AC run/size, ZRL, EOB) with category and amplitude bits. It sits between the zigzag stage and the Huffman table-lookup/bit-packer.

---
 rtl/huffman_block_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_huffman_block_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_block_sequencer.sv
// huffman_block_sequencer: accepts one zigzag-ordered quantised block per
// handshake, keeps a DC predictor per colour component, scans the AC
// coefficients one per cycle and emits a backpressured stream of JPEG
// symbols (DC, AC run/size, ZRL, EOB) with category and amplitude bits.
//
// Ports:
//   clock_i, reset_n_i          clock (rising edge), async active-low reset
//   block_valid_i/block_ready_o block handshake
//   block_comp_i                component index (>= NUM_COMP maps to 0)
//   block_coef_i                BLOCK_N coefficients, coef i at [i*COEF_W +: COEF_W]
//   sym_valid_o/sym_ready_i     symbol handshake
//   sym_type_o                  0=DC 1=AC 2=ZRL 3=EOB
//   sym_run_o, sym_size_o       zero run and magnitude category
//   sym_amp_o                   right-aligned amplitude bits
//   sym_last_o                  final symbol of the block
//   busy_o                      high when not idle
//   restart_i                   clears all predictors (HUFF_SEQ_RESTART_EN only)
//
// Optional feature macro: HUFF_SEQ_RESTART_EN
module huffman_block_sequencer #(
   parameter int unsigned COEF_W   = 12,
   parameter int unsigned BLOCK_N  = 64,
   parameter int unsigned NUM_COMP = 3
) (
   input  logic                      clock_i,
   input  logic                      reset_n_i,
   input  logic                      block_valid_i,
   output logic                      block_ready_o,
   input  logic [1:0]                block_comp_i,
   input  logic [BLOCK_N*COEF_W-1:0] block_coef_i,
   output logic                      sym_valid_o,
   input  logic                      sym_ready_i,
   output logic [1:0]                sym_type_o,
   output logic [3:0]                sym_run_o,
   output logic [3:0]                sym_size_o,
   output logic [COEF_W:0]           sym_amp_o,
   output logic                      sym_last_o,
`ifdef HUFF_SEQ_RESTART_EN
   input  logic                      restart_i,
`endif
   output logic                      busy_o
);

   localparam int unsigned AW    = COEF_W + 1;
   localparam int unsigned IDX_W = $clog2(BLOCK_N);
   localparam int unsigned RUN_W = 6;
   localparam int unsigned CW    = BLOCK_N * COEF_W;

   localparam logic [1:0] T_DC  = 2'd0;
   localparam logic [1:0] T_AC  = 2'd1;
   localparam logic [1:0] T_ZRL = 2'd2;
   localparam logic [1:0] T_EOB = 2'd3;

   typedef enum logic [2:0] {S_IDLE, S_DC, S_SCAN, S_EMIT, S_EOB} state_e;

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [RUN_W-1:0]          run_q, run_d;
   logic [CW-1:0]             coef_q, coef_d;
   logic signed [COEF_W-1:0]  pred_q [4];
   logic signed [COEF_W-1:0]  pred_d [4];
   logic                      ready_q, ready_d;
   logic                      busy_q, busy_d;
   logic                      valid_q, valid_d;
   logic [1:0]                type_q, type_d;
   logic [3:0]                srun_q, srun_d;
   logic [3:0]                size_q, size_d;
   logic [AW-1:0]             amp_q, amp_d;
   logic                      last_q, last_d;

   logic [1:0]                comp_c;
   logic signed [COEF_W-1:0]  coef0_c;
   logic signed [COEF_W-1:0]  cur_c;
   logic signed [AW-1:0]      diff_c;
   logic signed [AW-1:0]      cur_ext_c;
   logic [3:0]                dsize_c;
   logic [3:0]                csize_c;

   // Bit length of |v|; size(0) = 0.
   function automatic logic [3:0] size_of(input logic signed [AW-1:0] v);
      logic [AW-1:0] mag;
      size_of = 4'd0;
      mag = v[AW-1] ? (~v + AW'(1)) : v;
      for (int unsigned i = 0; i < AW; i++) begin
         if (mag[i]) size_of = 4'(i + 1);
      end
   endfunction

   // Negative values are sent as (v-1) truncated to size bits.
   function automatic logic [AW-1:0] amp_of(input logic signed [AW-1:0] v,
                                            input logic [3:0] sz);
      logic [AW-1:0] mask;
      mask   = (AW'(1) << sz) - AW'(1);
      amp_of = v[AW-1] ? ((v - AW'(1)) & mask) : v;
   endfunction

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      run_d   = run_q;
      coef_d  = coef_q;
      pred_d  = pred_q;
      valid_d = valid_q;
      type_d  = type_q;
      srun_d  = srun_q;
      size_d  = size_q;
      amp_d   = amp_q;
      last_d  = last_q;

      comp_c  = ({1'b0, block_comp_i} < 3'(NUM_COMP)) ? block_comp_i : 2'd0;
      coef0_c = block_coef_i[COEF_W-1:0];
      cur_c   = coef_q[32'(idx_q) * COEF_W +: COEF_W];

`ifdef HUFF_SEQ_RESTART_EN
      if (restart_i) begin
         for (int i = 0; i < 4; i++) pred_d[i] = '0;
      end
`endif
      // pred_d already reflects a coincident restart here
      diff_c    = {coef0_c[COEF_W-1], coef0_c} - {pred_d[comp_c][COEF_W-1], pred_d[comp_c]};
      cur_ext_c = {cur_c[COEF_W-1], cur_c};
      dsize_c   = size_of(diff_c);
      csize_c   = size_of(cur_ext_c);

      unique case (state_q)
         S_IDLE: begin
            if (block_valid_i && ready_q) begin
               coef_d         = block_coef_i;
               pred_d[comp_c] = coef0_c;
               valid_d        = 1'b1;
               type_d         = T_DC;
               srun_d         = 4'd0;
               size_d         = dsize_c;
               amp_d          = amp_of(diff_c, dsize_c);
               last_d         = 1'b0;
               state_d        = S_DC;
            end
         end
         S_DC: begin
            if (sym_ready_i) begin
               valid_d = 1'b0;
               idx_d   = IDX_W'(1);
               run_d   = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (cur_c == '0) begin
               if (idx_q == IDX_W'(BLOCK_N - 1)) begin
                  valid_d = 1'b1;
                  type_d  = T_EOB;
                  srun_d  = 4'd0;
                  size_d  = 4'd0;
                  amp_d   = '0;
                  last_d  = 1'b1;
                  state_d = S_EOB;
               end else begin
                  run_d = run_q + RUN_W'(1);
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (run_q >= RUN_W'(16)) begin
               // idx is held so this coefficient is re-examined after the ZRL
               valid_d = 1'b1;
               type_d  = T_ZRL;
               srun_d  = 4'd15;
               size_d  = 4'd0;
               amp_d   = '0;
               last_d  = 1'b0;
               run_d   = run_q - RUN_W'(16);
               state_d = S_EMIT;
            end else begin
               valid_d = 1'b1;
               type_d  = T_AC;
               srun_d  = run_q[3:0];
               size_d  = csize_c;
               amp_d   = amp_of(cur_ext_c, csize_c);
               last_d  = (idx_q == IDX_W'(BLOCK_N - 1));
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (sym_ready_i) begin
               valid_d = 1'b0;
               if (type_q == T_ZRL) begin
                  state_d = S_SCAN;
               end else if (last_q) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  run_d   = '0;
                  state_d = S_SCAN;
               end
            end
         end
         S_EOB: begin
            if (sym_ready_i) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         run_q   <= '0;
         coef_q  <= '0;
         for (int i = 0; i < 4; i++) pred_q[i] <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         type_q  <= 2'd0;
         srun_q  <= 4'd0;
         size_q  <= 4'd0;
         amp_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         run_q   <= run_d;
         coef_q  <= coef_d;
         pred_q  <= pred_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         type_q  <= type_d;
         srun_q  <= srun_d;
         size_q  <= size_d;
         amp_q   <= amp_d;
         last_q  <= last_d;
      end
   end

   assign block_ready_o = ready_q;
   assign busy_o        = busy_q;
   assign sym_valid_o   = valid_q;
   assign sym_type_o    = type_q;
   assign sym_run_o     = srun_q;
   assign sym_size_o    = size_q;
   assign sym_amp_o     = amp_q;
   assign sym_last_o    = last_q;

endmodule

// File: tb/tb_huffman_block_sequencer.sv
// Directed bench for huffman_block_sequencer: hand-computed symbol streams,
// stall stability, latency, component clamping and mid-block reset.
module tb_huffman_block_sequencer;

   localparam int unsigned COEF_W   = 12;
   localparam int unsigned BLOCK_N  = 64;
   localparam int unsigned NUM_COMP = 3;
   localparam int unsigned AW       = COEF_W + 1;
   localparam int unsigned CW       = BLOCK_N * COEF_W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          block_valid = 1'b0;
   logic          block_ready;
   logic [1:0]    block_comp = 2'd0;
   logic [CW-1:0] block_coef = '0;
   logic          sym_valid;
   logic          sym_ready = 1'b0;
   logic [1:0]    sym_type;
   logic [3:0]    sym_run;
   logic [3:0]    sym_size;
   logic [AW-1:0] sym_amp;
   logic          sym_last;
   logic          busy;
`ifdef HUFF_SEQ_RESTART_EN
   logic          restart = 1'b0;
`endif

   int            checks = 0;
   int            failures = 0;
   logic [31:0]   exp_q[$];
   logic [CW-1:0] blk;
   logic [31:0]   cur_sym;
   int            lc;
   int            pred2;

   assign cur_sym = {8'd0, sym_type, sym_run, sym_size, sym_amp, sym_last};

   huffman_block_sequencer #(
      .COEF_W(COEF_W), .BLOCK_N(BLOCK_N), .NUM_COMP(NUM_COMP)
   ) u_dut (
      .clock_i      (clk),
      .reset_n_i    (rst_n),
      .block_valid_i(block_valid),
      .block_ready_o(block_ready),
      .block_comp_i (block_comp),
      .block_coef_i (block_coef),
      .sym_valid_o  (sym_valid),
      .sym_ready_i  (sym_ready),
      .sym_type_o   (sym_type),
      .sym_run_o    (sym_run),
      .sym_size_o   (sym_size),
      .sym_amp_o    (sym_amp),
      .sym_last_o   (sym_last),
`ifdef HUFF_SEQ_RESTART_EN
      .restart_i    (restart),
`endif
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int t, input int r, input int s, input int a, input bit l);
      return {8'd0, 2'(t), 4'(r), 4'(s), AW'(a), l};
   endfunction

   task automatic push(input int t, input int r, input int s, input int a, input bit l);
      exp_q.push_back(mk(t, r, s, a, l));
   endtask

   task automatic set_coef(input int k, input int v);
      blk[k*COEF_W +: COEF_W] = COEF_W'(v);
   endtask

   function automatic int sz_m(input int v);
      int m, s;
      m = (v < 0) ? -v : v;
      s = 0;
      while (m > 0) begin s++; m = m >>> 1; end
      return s;
   endfunction

   function automatic int amp_m(input int v);
      int s;
      s = sz_m(v);
      return (v < 0) ? ((v - 1) & ((1 << s) - 1)) : v;
   endfunction

   // Reference symbol stream for a block given the component's predictor.
   task automatic model_block(input logic [CW-1:0] b, input int pred);
      logic signed [COEF_W-1:0] c;
      int v, run;
      c = b[COEF_W-1:0];
      v = int'(c) - pred;
      push(0, 0, sz_m(v), amp_m(v), 1'b0);
      run = 0;
      for (int k = 1; k < int'(BLOCK_N); k++) begin
         c = b[k*COEF_W +: COEF_W];
         v = int'(c);
         if (v == 0) begin
            run++;
            if (k == int'(BLOCK_N) - 1) push(3, 0, 0, 0, 1'b1);
         end else begin
            while (run >= 16) begin push(2, 15, 0, 0, 1'b0); run -= 16; end
            push(1, run, sz_m(v), amp_m(v), k == int'(BLOCK_N) - 1);
            run = 0;
         end
      end
   endtask

   // Offers one block, drains the expected queue with optional random stalls.
   task automatic run_block(input string tag, input logic [1:0] comp, input logic [CW-1:0] coef,
                            input int stall_pct, output int last_cyc);
      int n_exp, got_n, cyc;
      bit stalled;
      logic [31:0] held;
      n_exp = exp_q.size();
      block_comp = comp;
      block_coef = coef;
      block_valid = 1'b1;
      cyc = 0;
      while (!block_ready && cyc < 100) begin @(negedge clk); cyc++; end
      check({tag, ":accept"}, 32'(block_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      block_valid = 1'b0;
      got_n = 0; cyc = 0; stalled = 1'b0; held = '0; last_cyc = -1;
      while (got_n < n_exp && cyc < 4000) begin
         if (stalled)
            check({tag, ":hold"}, {7'd0, sym_valid, cur_sym[23:0]}, {7'd0, 1'b1, held[23:0]});
         if (sym_valid) begin
            sym_ready = ($urandom_range(99) >= 32'(stall_pct));
            if (sym_ready) begin
               check(tag, cur_sym, exp_q.pop_front());
               got_n++;
               stalled = 1'b0;
               last_cyc = cyc;
            end else begin
               stalled = 1'b1;
               held = cur_sym;
            end
         end else begin
            stalled = 1'b0;
            sym_ready = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      check({tag, ":count"}, 32'(got_n), 32'(n_exp));
      sym_ready = 1'b0;
      check({tag, ":idle"}, {29'd0, sym_valid, block_ready, busy}, 32'b010);
      exp_q.delete();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(block_ready), 32'd0);
      check("rst_sym", {7'd0, sym_valid, cur_sym[23:0]}, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(block_ready), 32'd1);

      // coef0=-5 on comp0: DC size 3 amp 010, EOB at cycle BLOCK_N
      blk = '0; set_coef(0, -5);
      push(0, 0, 3, 2, 1'b0); push(3, 0, 0, 0, 1'b1);
      run_block("t1", 2'd0, blk, 0, lc);
      check("t1_eob_lat", 32'(lc), 32'(BLOCK_N));

      // comp2 predictor chain 10 then 7, comp1 unaffected, comp3 clamps to comp0
      blk = '0; set_coef(0, 10);
      push(0, 0, 4, 10, 1'b0); push(3, 0, 0, 0, 1'b1);
      run_block("t2a", 2'd2, blk, 0, lc);
      blk = '0; set_coef(0, 7);
      push(0, 0, 2, 0, 1'b0); push(3, 0, 0, 0, 1'b1);
      run_block("t2b", 2'd2, blk, 0, lc);
      blk = '0; set_coef(0, 7);
      push(0, 0, 3, 7, 1'b0); push(3, 0, 0, 0, 1'b1);
      run_block("t2c", 2'd1, blk, 0, lc);
      blk = '0; set_coef(0, -5);
      push(0, 0, 0, 0, 1'b0); push(3, 0, 0, 0, 1'b1);
      run_block("t2d", 2'd3, blk, 0, lc);

      // coef1=3, coef20=-1 with stalls
      blk = '0; set_coef(0, -5); set_coef(1, 3); set_coef(20, -1);
      push(0, 0, 0, 0, 1'b0); push(1, 0, 2, 3, 1'b0); push(2, 15, 0, 0, 1'b0);
      push(1, 2, 1, 0, 1'b0); push(3, 0, 0, 0, 1'b1);
      run_block("t3", 2'd0, blk, 30, lc);

      // only the last coefficient nonzero: three ZRLs, last AC, no EOB
      blk = '0; set_coef(0, 7); set_coef(63, 1);
      push(0, 0, 0, 0, 1'b0);
      push(2, 15, 0, 0, 1'b0); push(2, 15, 0, 0, 1'b0); push(2, 15, 0, 0, 1'b0);
      push(1, 14, 1, 1, 1'b1);
      run_block("t4", 2'd1, blk, 30, lc);

      // random sparse blocks on comp2 against the reference stream
      pred2 = 7;
      for (int n = 0; n < 4; n++) begin
         blk = '0;
         for (int k = 0; k < int'(BLOCK_N); k++) begin
            if (k == 0 || $urandom_range(99) < 25)
               set_coef(k, int'($urandom_range(4095)) - 2048);
         end
         model_block(blk, pred2);
         pred2 = int'($signed(blk[COEF_W-1:0]));
         run_block("t5", 2'd2, blk, 30, lc);
      end

      // reset mid-scan aborts the block and clears predictors
      blk = '0; set_coef(0, 3); set_coef(40, 5);
      block_comp = 2'd0; block_coef = blk; block_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      block_valid = 1'b0;
      sym_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("t6_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_abort", {29'd0, sym_valid, block_ready, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sym_ready = 1'b0;
      @(negedge clk);
      check("t6_release", {30'd0, sym_valid, block_ready}, 32'b01);
      blk = '0; set_coef(0, 9);
      push(0, 0, 4, 9, 1'b0); push(3, 0, 0, 0, 1'b1);
      run_block("t6", 2'd0, blk, 0, lc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
